// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: instruction-cache lookup and line-fill sequencer in front of the tag/flag RAM.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_fill_ctrl #(
    parameter int PABITS     = 36,
    parameter int LINE_WORDS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Fetch_Req,
    input  logic [PABITS-1:0] Fetch_PAddr,
    output logic              Fetch_Ready,
    input  logic              Inv_Req,
    input  logic [7:0]        Inv_Index,
    output logic              Inv_Ack,
    output logic [7:0]        Tag_Index,
    output logic [PABITS-13:0] Tag_Cmp,
    output logic [PABITS-13:0] Tag_Set,
    output logic              Tag_Write,
    output logic              Tag_Valid,
    input  logic              MatchHit,
    input  logic              MatchValid,
    output logic [9:0]        Data_Addr,
    output logic              Data_Write,
    output logic [31:0]       Data_WData,
    output logic              Mem_Req,
    output logic [PABITS-1:0] Mem_Addr,
    input  logic              Mem_Ack,
    input  logic              Mem_RValid,
    input  logic [31:0]       Mem_RData
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       Hit_Count,
    output logic [31:0]       Miss_Count
`endif
);
    localparam int CW = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, FILL, TAG_WR, RELOOK, INV} state_t;

    state_t             state;
    logic [PABITS-13:0] tag_q;
    logic [7:0]         idx_q;
    logic [CW-1:0]      cnt;
    logic               hit;
    logic               take_fetch;
    logic               beat;
    logic               last;
    logic               unused_bits;

    assign unused_bits = ^Fetch_PAddr[3:0];

    always_comb begin
        hit         = MatchHit && MatchValid;
        take_fetch  = state == IDLE && !Inv_Req && Fetch_Req;
        // a beat arriving together with the grant counts as beat 0
        beat        = Mem_RValid && (state == FILL || (state == MISS_REQ && Mem_Ack));
        last        = beat && cnt == CW'(LINE_WORDS - 1);
        Tag_Index   = (take_fetch && reset) ? Fetch_PAddr[11:4] : idx_q;
        Tag_Cmp     = tag_q;
        Tag_Set     = tag_q;
        Mem_Addr    = {tag_q, idx_q, 4'h0};
        Data_Addr   = {idx_q, cnt};
        Data_Write  = beat;
        Data_WData  = beat ? Mem_RData : 32'h0;
        Fetch_Ready = state == LOOKUP && hit;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tag_q     <= '0;
            idx_q     <= '0;
            cnt       <= '0;
            Mem_Req   <= 1'b0;
            Tag_Write <= 1'b0;
            Tag_Valid <= 1'b0;
            Inv_Ack   <= 1'b0;
        end else begin
            Tag_Write <= 1'b0;
            Tag_Valid <= 1'b0;
            Inv_Ack   <= 1'b0;
            if (beat)
                cnt <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (Inv_Req) begin
                        idx_q     <= Inv_Index;
                        Tag_Write <= 1'b1;
                        Inv_Ack   <= 1'b1;
                        state     <= INV;
                    end else if (Fetch_Req) begin
                        tag_q <= Fetch_PAddr[PABITS-1:12];
                        idx_q <= Fetch_PAddr[11:4];
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        state <= IDLE;
                    end else begin
                        Mem_Req <= 1'b1;
                        cnt     <= '0;
                        state   <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (Mem_Ack) begin
                        Mem_Req <= 1'b0;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (last) begin
                        Tag_Write <= 1'b1;
                        Tag_Valid <= 1'b1;
                        state     <= TAG_WR;
                    end
                end
                TAG_WR:  state <= RELOOK;
                RELOOK:  state <= LOOKUP;
                INV:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic replay;

    // the lookup following a fill is a replay and is not counted as a hit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            replay     <= 1'b0;
            Hit_Count  <= '0;
            Miss_Count <= '0;
        end else begin
            if (state == TAG_WR)
                replay <= 1'b1;
            else if (state == LOOKUP)
                replay <= 1'b0;
            if (state == LOOKUP && hit && !replay && ~&Hit_Count)
                Hit_Count <= Hit_Count + 1'b1;
            if (state == LOOKUP && !hit && ~&Miss_Count)
                Miss_Count <= Miss_Count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: directed table, reset corner case and randomized fetch/invalidate traffic
// checked against a simple line-presence model of the cache.
module tb_icache_fill_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        Fetch_Req;
    logic [35:0] Fetch_PAddr;
    logic        Fetch_Ready;
    logic        Inv_Req;
    logic [7:0]  Inv_Index;
    logic        Inv_Ack;
    logic [7:0]  Tag_Index;
    logic [23:0] Tag_Cmp;
    logic [23:0] Tag_Set;
    logic        Tag_Write;
    logic        Tag_Valid;
    logic        MatchHit;
    logic        MatchValid;
    logic [9:0]  Data_Addr;
    logic        Data_Write;
    logic [31:0] Data_WData;
    logic        Mem_Req;
    logic [35:0] Mem_Addr;
    logic        Mem_Ack;
    logic        Mem_RValid;
    logic [31:0] Mem_RData;
`ifdef ICACHE_STATS_EN
    logic [31:0] Hit_Count;
    logic [31:0] Miss_Count;
`endif

    icache_fill_ctrl dut (
        .clock(clock), .reset(reset),
        .Fetch_Req(Fetch_Req), .Fetch_PAddr(Fetch_PAddr), .Fetch_Ready(Fetch_Ready),
        .Inv_Req(Inv_Req), .Inv_Index(Inv_Index), .Inv_Ack(Inv_Ack),
        .Tag_Index(Tag_Index), .Tag_Cmp(Tag_Cmp), .Tag_Set(Tag_Set),
        .Tag_Write(Tag_Write), .Tag_Valid(Tag_Valid),
        .MatchHit(MatchHit), .MatchValid(MatchValid),
        .Data_Addr(Data_Addr), .Data_Write(Data_Write), .Data_WData(Data_WData),
        .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr), .Mem_Ack(Mem_Ack),
        .Mem_RValid(Mem_RValid), .Mem_RData(Mem_RData)
`ifdef ICACHE_STATS_EN
        , .Hit_Count(Hit_Count), .Miss_Count(Miss_Count)
`endif
    );

    always #5 clock = ~clock;

    // tag/flag RAM: synchronous read, compare against the controller's compare tag
    logic [23:0] ram_tag [256];
    bit          ram_v   [256];
    bit   [7:0]  rd_idx;
    always @(posedge clock) begin
        if (Tag_Write) begin
            ram_tag[Tag_Index] <= Tag_Set;
            ram_v[Tag_Index]   <= Tag_Valid;
        end
        rd_idx <= Tag_Index;
    end
    assign MatchValid = ram_v[rd_idx];
    assign MatchHit   = MatchValid && ram_tag[rd_idx] == Tag_Cmp;

    // reference: which line is resident in each set
    bit          ref_v [256];
    logic [23:0] ref_t [256];
    int nvec = 0, nerr = 0, hits = 0, misses = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, {Fetch_Ready, Inv_Ack, Tag_Index, Tag_Write, Tag_Valid, Data_Addr,
                           Data_Write, Mem_Req, Tag_Cmp}, 64'h0);
        chk({nm, "_maddr"}, Mem_Addr, 64'h0);
        chk({nm, "_wd_set"}, {Data_WData, Tag_Set}, 64'h0);
    endtask

    task automatic do_fetch(input logic [35:0] a, input bit eh, input int ackd, input int gap,
                            input bit coin, input logic [31:0] dbase, input bit rnd);
        logic [7:0]  ix;
        logic [23:0] tg;
        logic [31:0] dv;
        int          b0;
        ix = a[11:4];
        tg = a[35:12];
        Fetch_Req = 1'b1;
        Fetch_PAddr = a;
        @(negedge clock);
        chk("idx_comb", Tag_Index, ix);
        tick();
        @(negedge clock);
        chk("lookup_ready", Fetch_Ready, eh);
        chk("lookup_memreq", Mem_Req, 0);
        if (eh) begin
            hits++;
            tick();
            Fetch_Req = 1'b0;
            return;
        end
        misses++;
        tick();
        for (int i = 0; i < ackd; i++) begin
            @(negedge clock);
            chk("memreq_wait", {Mem_Req, Mem_Addr}, {1'b1, tg, ix, 4'h0});
            tick();
        end
        dv = rnd ? $urandom : dbase;
        b0 = coin ? 1 : 0;
        Mem_Ack = 1'b1;
        Mem_RValid = coin;
        Mem_RData = dv;
        @(negedge clock);
        chk("memreq_ack", {Mem_Req, Mem_Addr}, {1'b1, tg, ix, 4'h0});
        if (coin)
            chk("ack_beat", {Data_Write, Data_Addr, Data_WData}, {1'b1, ix, 2'd0, dv});
        else
            chk("ack_nowrite", Data_Write, 0);
        tick();
        Mem_Ack = 1'b0;
        Mem_RValid = 1'b0;
        for (int b = b0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                chk("gap", {Data_Write, Mem_Req, Tag_Write}, 0);
                tick();
            end
            dv = rnd ? $urandom : dbase + 32'(b);
            Mem_RValid = 1'b1;
            Mem_RData = dv;
            @(negedge clock);
            chk("beat", {Data_Write, Tag_Write, Data_Addr, Data_WData}, {1'b1, 1'b0, ix, 2'(b), dv});
            tick();
            Mem_RValid = 1'b0;
        end
        @(negedge clock);
        chk("tag_wr", {Tag_Write, Tag_Valid, Tag_Index, Tag_Set, Data_Write}, {1'b1, 1'b1, ix, tg, 1'b0});
        tick();
        @(negedge clock);
        chk("relook", {Tag_Write, Tag_Index, Fetch_Ready}, {1'b0, ix, 1'b0});
        tick();
        @(negedge clock);
        chk("fill_ready", Fetch_Ready, 1);
        tick();
        Fetch_Req = 1'b0;
        ref_v[ix] = 1'b1;
        ref_t[ix] = tg;
    endtask

    task automatic do_inv(input logic [7:0] i, input bit with_fetch, input logic [35:0] a);
        Inv_Req = 1'b1;
        Inv_Index = i;
        if (with_fetch) begin
            Fetch_Req = 1'b1;
            Fetch_PAddr = a;
        end
        @(negedge clock);
        chk("inv_idle", {Tag_Write, Inv_Ack}, 0);
        tick();
        @(negedge clock);
        chk("inv", {Tag_Write, Tag_Valid, Inv_Ack, Tag_Index, Fetch_Ready, Mem_Req},
            {1'b1, 1'b0, 1'b1, i, 1'b0, 1'b0});
        tick();
        Inv_Req = 1'b0;
        ref_v[i] = 1'b0;
    endtask

    typedef struct {
        int          op;     // 0 fetch, 1 invalidate, 2 invalidate with fetch pending
        logic [35:0] a;
        logic [7:0]  ii;
        bit          eh;
        int          ackd;
        int          gap;
        bit          coin;
        logic [31:0] db;
    } vec_t;

    initial begin
        vec_t        tbl [8];
        logic [7:0]  pool [4];
        logic [23:0] tags [2];
        logic [35:0] a;
        logic [7:0]  ix;
        logic [23:0] tg;
        reset = 1'b0;
        Fetch_Req = 1'b0;
        Fetch_PAddr = '0;
        Inv_Req = 1'b0;
        Inv_Index = '0;
        Mem_Ack = 1'b0;
        Mem_RValid = 1'b0;
        Mem_RData = '0;
        tbl[0] = '{0, 36'h0_0000_1230, 8'h00, 1'b0, 0, 0, 1'b0, 32'hA0};
        tbl[1] = '{0, 36'h0_0000_1238, 8'h00, 1'b1, 0, 0, 1'b0, 32'h0};
        tbl[2] = '{0, 36'h0_0001_1230, 8'h00, 1'b0, 1, 1, 1'b1, 32'hB0};
        tbl[3] = '{1, 36'h0,           8'h23, 1'b0, 0, 0, 1'b0, 32'h0};
        tbl[4] = '{0, 36'h0_0001_1230, 8'h00, 1'b0, 5, 2, 1'b0, 32'hC0};
        tbl[5] = '{0, 36'h0_0001_1234, 8'h00, 1'b1, 0, 0, 1'b0, 32'h0};
        tbl[6] = '{2, 36'h0_0001_1230, 8'h23, 1'b0, 2, 0, 1'b1, 32'hD0};
        tbl[7] = '{0, 36'h0_0000_123C, 8'h00, 1'b0, 0, 1, 1'b0, 32'hE0};
        pool = '{8'h10, 8'h11, 8'h12, 8'h45};
        tags = '{24'h0000A1, 24'h0000B2};

        repeat (2) tick();
        chk_zero("reset");
`ifdef ICACHE_STATS_EN
        chk("stats_reset", {Hit_Count, Miss_Count}, 0);
`endif
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].op != 0)
                do_inv(tbl[i].ii, tbl[i].op == 2, tbl[i].a);
            if (tbl[i].op != 1)
                do_fetch(tbl[i].a, tbl[i].eh, tbl[i].ackd, tbl[i].gap, tbl[i].coin, tbl[i].db, 1'b0);
        end

        // reset in the middle of a fill, with stray beats around it
        a = 36'h0_0002_0450;
        Fetch_Req = 1'b1;
        Fetch_PAddr = a;
        tick();
        tick();
        Mem_Ack = 1'b1;
        tick();
        Mem_Ack = 1'b0;
        Mem_RValid = 1'b1;
        Mem_RData = 32'h11;
        tick();
        Mem_RData = 32'h22;
        tick();
        Mem_RData = 32'h33;
        #2;
        reset = 1'b0;
        #1;
        chk_zero("midfill_reset");
        hits = 0;
        misses = 0;
        @(negedge clock);
        chk("reset_stray", Data_Write, 0);
`ifdef ICACHE_STATS_EN
        chk("stats_cleared", {Hit_Count, Miss_Count}, 0);
`endif
        tick();
        Fetch_Req = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("post_reset_stray", {Data_Write, Mem_Req, Tag_Write}, 0);
        tick();
        Mem_RValid = 1'b0;
        do_fetch(a, 1'b0, 1, 0, 1'b0, 32'h40, 1'b0);
        do_fetch(a, 1'b1, 0, 0, 1'b0, 32'h0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ix = pool[$urandom_range(0, 3)];
            tg = tags[$urandom_range(0, 1)];
            if ($urandom_range(0, 9) < 2) begin
                do_inv(ix, 1'b0, 36'h0);
            end else begin
                a = {tg, ix, 4'($urandom_range(0, 15))};
                do_fetch(a, ref_v[ix] && ref_t[ix] == tg, $urandom_range(0, 3),
                         $urandom_range(0, 2), 1'($urandom_range(0, 1)), 32'h0, 1'b1);
            end
        end

`ifdef ICACHE_STATS_EN
        chk("hit_count", Hit_Count, 64'(hits));
        chk("miss_count", Miss_Count, 64'(misses));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
